// File: rtl/demultiplexer4_router_pkg.sv
// Shared constants for the 4-way registered demultiplexer: channel selector
// encodings and the channel count.
package demultiplexer4_router_pkg;

    localparam int unsigned NUM_CHANNELS = 4;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot: holds a word until the downstream channel takes it,
// and counts every word pushed into it.
module demux_out_slot #(
    parameter int unsigned bitwidth  = 32,
    parameter int unsigned cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [bitwidth-1:0]  in_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [bitwidth-1:0]  out_data,
    output logic [cnt_width-1:0] count
);

    logic                 full_q, full_d;
    logic [bitwidth-1:0]  data_q, data_d;
    logic [cnt_width-1:0] count_q, count_d;

    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        count_d = count_q;
        if (full_q && out_ready) begin
            full_d = 1'b0;
        end
        // A push may coincide with a pop; the new word simply replaces the old one.
        if (push) begin
            full_d  = 1'b1;
            data_d  = in_data;
            count_d = count_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q  <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign count     = count_q;

endmodule

// File: rtl/demultiplexer4_router.sv
// 4-way registered demultiplexer: routes a valid/ready stream to one of four
// single-entry output slots selected by in_sel.
module demultiplexer4_router
    import demultiplexer4_router_pkg::*;
#(
    parameter int unsigned bitwidth  = 32,
    parameter int unsigned cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [bitwidth-1:0]  in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [bitwidth-1:0]  out_a,
    output logic [bitwidth-1:0]  out_b,
    output logic [bitwidth-1:0]  out_c,
    output logic [bitwidth-1:0]  out_d,
    output logic [cnt_width-1:0] count_a,
    output logic [cnt_width-1:0] count_b,
    output logic [cnt_width-1:0] count_c,
    output logic [cnt_width-1:0] count_d
);

    logic [NUM_CHANNELS-1:0] push;
    logic [bitwidth-1:0]     slot_data  [NUM_CHANNELS];
    logic [cnt_width-1:0]    slot_count [NUM_CHANNELS];

    // Only the selected slot matters: other channels never stall the input.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

    always_comb begin
        push = '0;
        if (in_valid && in_ready) begin
            unique case (in_sel)
                SEL_A: push[0] = 1'b1;
                SEL_B: push[1] = 1'b1;
                SEL_C: push[2] = 1'b1;
                SEL_D: push[3] = 1'b1;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_slot
        demux_out_slot #(
            .bitwidth  (bitwidth),
            .cnt_width (cnt_width)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push[i]),
            .in_data   (in_data),
            .out_ready (out_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (slot_data[i]),
            .count     (slot_count[i])
        );
    end

    assign out_a   = slot_data[0];
    assign out_b   = slot_data[1];
    assign out_c   = slot_data[2];
    assign out_d   = slot_data[3];
    assign count_a = slot_count[0];
    assign count_b = slot_count[1];
    assign count_c = slot_count[2];
    assign count_d = slot_count[3];

endmodule

// File: tb/tb_demultiplexer4_router.sv
// Scoreboard bench for demultiplexer4_router: accepted words are queued per
// channel and a negedge monitor checks delivery, valid flags and counters.
module tb_demultiplexer4_router;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_a, out_b, out_c, out_d;
    logic [7:0]  count_a, count_b, count_c, count_d;

    logic [31:0] outs [4];
    logic [7:0]  cnts [4];

    logic [31:0] exp_q [4][$];
    logic [7:0]  exp_cnt [4];

    int unsigned vectors;
    int unsigned miscompares;

    demultiplexer4_router #(
        .bitwidth  (32),
        .cnt_width (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .count_a   (count_a),
        .count_b   (count_b),
        .count_c   (count_c),
        .count_d   (count_d)
    );

    assign outs[0] = out_a;
    assign outs[1] = out_b;
    assign outs[2] = out_c;
    assign outs[3] = out_d;
    assign cnts[0] = count_a;
    assign cnts[1] = count_b;
    assign cnts[2] = count_c;
    assign cnts[3] = count_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle, pop the expected word whenever a channel hands off.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid[%0d]", i), {31'b0, out_valid[i]},
                {31'b0, exp_q[i].size() != 0});
            if (out_valid[i] && exp_q[i].size() != 0) begin
                chk($sformatf("data[%0d]", i), outs[i], exp_q[i][0]);
                if (out_ready[i]) void'(exp_q[i].pop_front());
            end
            chk($sformatf("count[%0d]", i), {24'b0, cnts[i]}, {24'b0, exp_cnt[i]});
        end
    end

    // Drive one cycle starting just after a posedge; ends just after the next one.
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] r, output logic hs);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #3;
        hs = in_valid && in_ready;
        @(posedge clk);
        if (hs) begin
            exp_q[s].push_back(d);
            exp_cnt[s] = exp_cnt[s] + 8'd1;
        end
        #1;
    endtask

    task automatic async_reset();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            exp_cnt[i] = 8'd0;
        end
        #1;
        chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_count[%0d]", i), {24'b0, cnts[i]}, 32'h0);
            chk($sformatf("rst_out[%0d]", i), outs[i], 32'h0);
        end
        reset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst_in_ready_sel%0d", s), {31'b0, in_ready}, 32'h1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        hs;
        logic        hold;
        logic [1:0]  s;
        logic [31:0] d;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'b00;
        in_data   = 32'h0;
        out_ready = 4'b0000;
        #3;
        chk("por_out_valid", {28'b0, out_valid}, 32'h0);
        chk("por_count_a", {24'b0, count_a}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Routing sweep
        step(1'b1, 2'b00, 32'h11111111, 4'b1111, hs);
        chk("sweep_a_valid", {28'b0, out_valid}, 32'h1);
        chk("sweep_a_data", out_a, 32'h11111111);
        step(1'b1, 2'b01, 32'h22222222, 4'b1111, hs);
        chk("sweep_b_valid", {28'b0, out_valid}, 32'h2);
        chk("sweep_b_data", out_b, 32'h22222222);
        step(1'b1, 2'b10, 32'h33333333, 4'b1111, hs);
        chk("sweep_c_valid", {28'b0, out_valid}, 32'h4);
        chk("sweep_c_data", out_c, 32'h33333333);
        step(1'b1, 2'b11, 32'h44444444, 4'b1111, hs);
        chk("sweep_d_valid", {28'b0, out_valid}, 32'h8);
        chk("sweep_d_data", out_d, 32'h44444444);
        step(1'b0, 2'b00, 32'h0, 4'b1111, hs);
        chk("sweep_drained", {28'b0, out_valid}, 32'h0);
        chk("sweep_a_kept", out_a, 32'h11111111);
        chk("sweep_count_a", {24'b0, count_a}, 32'h1);
        chk("sweep_count_d", {24'b0, count_d}, 32'h1);

        // Back-pressure on b, c still accepted
        async_reset();
        step(1'b1, 2'b01, 32'hAAAAAAAA, 4'b0000, hs);
        chk("bp_first_accept", {31'b0, hs}, 32'h1);
        chk("bp_valid_b", {28'b0, out_valid}, 32'h2);
        step(1'b1, 2'b01, 32'hBBBBBBBB, 4'b0000, hs);
        chk("bp_second_refused", {31'b0, hs}, 32'h0);
        chk("bp_out_b_stable", out_b, 32'hAAAAAAAA);
        step(1'b1, 2'b10, 32'hCCCCCCCC, 4'b0000, hs);
        chk("bp_c_accept", {31'b0, hs}, 32'h1);
        chk("bp_valid_bc", {28'b0, out_valid}, 32'h6);

        // Simultaneous push/pop on c
        async_reset();
        step(1'b1, 2'b10, 32'h33333333, 4'b0000, hs);
        step(1'b1, 2'b10, 32'h55555555, 4'b0100, hs);
        chk("pp_in_ready", {31'b0, hs}, 32'h1);
        chk("pp_valid_c", {31'b0, out_valid[2]}, 32'h1);
        chk("pp_out_c", out_c, 32'h55555555);
        chk("pp_count_c", {24'b0, count_c}, 32'h2);

        // Mid-operation reset with all slots full
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 32'hF0000000 + 32'(i), 4'b0000, hs);
        chk("fill_all_valid", {28'b0, out_valid}, 32'hF);
        async_reset();

        // Counter wrap on d
        for (int i = 0; i < 256; i++) step(1'b1, 2'b11, 32'(i), 4'b1111, hs);
        step(1'b0, 2'b00, 32'h0, 4'b1111, hs);
        chk("wrap_count_d", {24'b0, count_d}, 32'h0);
        chk("wrap_count_a", {24'b0, count_a}, 32'h0);
        chk("wrap_count_b", {24'b0, count_b}, 32'h0);
        chk("wrap_count_c", {24'b0, count_c}, 32'h0);
        chk("wrap_last_d", out_d, 32'h000000FF);

        // Random soak; a refused word is held stable until accepted
        hold = 1'b0;
        s    = 2'b00;
        d    = 32'h0;
        for (int n = 0; n < 10000; n++) begin
            if (!hold) begin
                s = 2'($urandom_range(0, 3));
                d = $urandom;
            end
            step(hold || ($urandom_range(0, 3) != 0), s, d, 4'($urandom_range(0, 15)), hs);
            hold = in_valid && !hs;
        end
        in_valid = 1'b0;
        for (int n = 0; n < 3; n++) step(1'b0, 2'b00, 32'h0, 4'b1111, hs);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("soak_drained[%0d]", i), 32'(exp_q[i].size()), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
